// File: rtl/coord_addr_pkg.sv
// Shared frame geometry, coordinate/address types and tag-width helper
// for the coordinate-to-address arbiter.
package coord_addr_pkg;

    localparam int IMG_W = 640;
    localparam int IMG_H = 480;
    localparam int CW    = 13;
    localparam int AW    = 20;

    typedef logic [CW-1:0] coord_t;
    typedef logic [AW-1:0] addr_t;

    // A single requester still needs one tag bit on the output bus.
    function automatic int tag_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searched from a rotating
// pointer, pointer moves past the winner whenever a grant is issued.
module rr_arbiter
    import coord_addr_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int TW      = tag_width(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               enable,
    output logic [NUM_REQ-1:0] gnt,
    output logic [TW-1:0]      idx
);

    logic [TW-1:0] ptr;
    logic [TW-1:0] cand;
    logic          hit;

    always_comb begin
        gnt  = '0;
        idx  = '0;
        hit  = 1'b0;
        cand = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = TW'((int'(ptr) + i) % NUM_REQ);
            if (enable && !hit && req[cand]) begin
                hit       = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

    // Without a grant the pointer holds, so an idle cycle never skips anyone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (hit) begin
            ptr <= (int'(idx) == NUM_REQ - 1) ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/coord_addr_arbiter.sv
// Shares one two-stage Y*IMG_W+X address pipeline between NUM_REQ requesters.
// Define COORD_CLIP_EN to clamp out-of-frame coordinates to the frame edge.
module coord_addr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IMG_W   = coord_addr_pkg::IMG_W,
    parameter int IMG_H   = coord_addr_pkg::IMG_H,
    parameter int CW      = coord_addr_pkg::CW,
    parameter int AW      = coord_addr_pkg::AW,
    parameter int TW      = coord_addr_pkg::tag_width(NUM_REQ)
) (
    input  logic                  iCLK,
    input  logic                  iRST_N,
    input  logic [NUM_REQ-1:0]    iReq,
    input  logic [NUM_REQ*CW-1:0] iX,
    input  logic [NUM_REQ*CW-1:0] iY,
    output logic [NUM_REQ-1:0]    oGnt,
    output logic                  oValid,
    input  logic                  iReady,
    output logic [AW-1:0]         oAddr,
    output logic [TW-1:0]         oTag,
    output logic                  oErr,
    output logic                  oBusy
);

    import coord_addr_pkg::*;

    localparam logic [CW-1:0] X_LIM = CW'(IMG_W);
    localparam logic [CW-1:0] Y_LIM = CW'(IMG_H);

    logic               s1_valid;
    logic [AW-1:0]      s1_prod;
    logic [CW-1:0]      s1_x;
    logic [TW-1:0]      s1_tag;
    logic               s1_err;
    logic               s2_valid;

    logic               advance;
    logic               s2_load;
    logic               any_gnt;
    logic [NUM_REQ-1:0] gnt;
    logic [TW-1:0]      gnt_idx;
    logic [CW-1:0]      sel_x;
    logic [CW-1:0]      sel_y;
    logic [CW-1:0]      use_x;
    logic [CW-1:0]      use_y;
    logic               sel_err;

    // S2 frees up on a transfer; S1 may accept whenever it is empty or drains.
    assign s2_load = !s2_valid || iReady;
    assign advance = !s1_valid || s2_load;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .TW      (TW)
    ) u_arb (
        .clk    (iCLK),
        .rst_n  (iRST_N),
        .req    (iReq),
        .enable (advance && iRST_N),
        .gnt    (gnt),
        .idx    (gnt_idx)
    );

    assign any_gnt = |gnt;
    assign oGnt    = gnt;

    always_comb begin
        sel_x   = iX[int'(gnt_idx)*CW +: CW];
        sel_y   = iY[int'(gnt_idx)*CW +: CW];
        sel_err = (sel_x >= X_LIM) || (sel_y >= Y_LIM);
`ifdef COORD_CLIP_EN
        use_x   = (sel_x >= X_LIM) ? X_LIM - 1'b1 : sel_x;
        use_y   = (sel_y >= Y_LIM) ? Y_LIM - 1'b1 : sel_y;
`else
        use_x   = sel_x;
        use_y   = sel_y;
`endif
    end

    // Multiply in S1, add in S2, keeping each stage to one arithmetic step.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            s1_valid <= 1'b0;
            s1_prod  <= '0;
            s1_x     <= '0;
            s1_tag   <= '0;
            s1_err   <= 1'b0;
        end else if (advance) begin
            s1_valid <= any_gnt;
            if (any_gnt) begin
                s1_prod <= AW'(use_y) * AW'(IMG_W);
                s1_x    <= use_x;
                s1_tag  <= gnt_idx;
                s1_err  <= sel_err;
            end
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            s2_valid <= 1'b0;
            oAddr    <= '0;
            oTag     <= '0;
            oErr     <= 1'b0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                oAddr <= s1_prod + AW'(s1_x);
                oTag  <= s1_tag;
                oErr  <= s1_err;
            end
        end
    end

    assign oValid = s2_valid;
    assign oBusy  = s1_valid || s2_valid;

endmodule

// File: tb/tb_coord_addr_arbiter.sv
// Self-checking bench for coord_addr_arbiter against a queue-based reference
// model of grants, address arithmetic and in-order delivery.
module tb_coord_addr_arbiter;

    localparam int NR = 3;
    localparam int W  = 640;
    localparam int H  = 480;
    localparam int CW = 13;
    localparam int AW = 20;
    localparam int TW = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NR-1:0]    req;
    logic [NR*CW-1:0] xs;
    logic [NR*CW-1:0] ys;
    logic             ready;
    logic [NR-1:0]    gnt;
    logic             valid;
    logic [AW-1:0]    addr;
    logic [TW-1:0]    tag;
    logic             err;
    logic             busy;

    coord_addr_arbiter #(.NUM_REQ(NR)) dut (
        .iCLK   (clk),
        .iRST_N (rst_n),
        .iReq   (req),
        .iX     (xs),
        .iY     (ys),
        .oGnt   (gnt),
        .oValid (valid),
        .iReady (ready),
        .oAddr  (addr),
        .oTag   (tag),
        .oErr   (err),
        .oBusy  (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   addr;
        int   tag;
        logic err;
        int   g;
    } txn_t;

    txn_t          q[$];
    txn_t          head;
    int            ptr_m;
    int            edge_cnt;
    int            n_tests;
    int            n_fail;
    logic [NR-1:0] obs_gnt;
    logic [NR-1:0] exp_gnt;
    logic          obs_valid;
    logic          exp_valid;
    logic [AW-1:0] obs_addr;
    logic [TW-1:0] obs_tag;
    logic          obs_err;
    logic          obs_busy;
    logic          exp_busy;

    function automatic txn_t make_txn(int r);
        txn_t t;
        int   x;
        int   y;
        x     = int'(xs[r*CW +: CW]);
        y     = int'(ys[r*CW +: CW]);
        t.err = (x >= W) || (y >= H);
`ifdef COORD_CLIP_EN
        if (x > W - 1) x = W - 1;
        if (y > H - 1) y = H - 1;
`endif
        t.addr = (y * W + x) % (1 << AW);
        t.tag  = r;
        t.g    = 0;
        return t;
    endfunction

    task automatic set_xy(input int r, input int x, input int y);
        xs[r*CW +: CW] = CW'(x);
        ys[r*CW +: CW] = CW'(y);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        req   = '0;
        ready = 1'b1;
        xs    = '0;
        ys    = '0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        q.delete();
        ptr_m = 0;
    endtask

    // One clock: observe at negedge, predict, then advance the model at posedge.
    task automatic tick();
        int   rg;
        bit   adv;
        txn_t nt;
        @(negedge clk);
        exp_valid = (q.size() > 0) && (edge_cnt >= q[0].g + 1);
        exp_busy  = (q.size() > 0);
        if (q.size() > 0) head = q[0];
        adv     = (q.size() < 2) || ready;
        exp_gnt = '0;
        rg      = -1;
        if (adv) begin
            for (int i = 0; i < NR; i++) begin
                int c;
                c = (ptr_m + i) % NR;
                if (rg < 0 && req[c]) rg = c;
            end
        end
        if (rg >= 0) begin
            exp_gnt[rg] = 1'b1;
            nt = make_txn(rg);
        end
        obs_gnt   = gnt;
        obs_valid = valid;
        obs_addr  = addr;
        obs_tag   = tag;
        obs_err   = err;
        obs_busy  = busy;
        @(posedge clk);
        edge_cnt++;
        if (exp_valid && ready) void'(q.pop_front());
        if (rg >= 0) begin
            nt.g = edge_cnt;
            q.push_back(nt);
            ptr_m = (rg + 1) % NR;
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = '1;
        ready = 1'b1;
        xs    = '0;
        ys    = '0;
        #3;
        n_tests++; if (gnt !== '0)   begin n_fail++; $display("[TB] FAIL reset_gnt got %b expected 0", gnt); end
        n_tests++; if (valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid got %b expected 0", valid); end
        n_tests++; if (addr !== '0)  begin n_fail++; $display("[TB] FAIL reset_addr got %0d expected 0", addr); end
        n_tests++; if (tag !== '0)   begin n_fail++; $display("[TB] FAIL reset_tag got %0d expected 0", tag); end
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_err got %b expected 0", err); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy got %b expected 0", busy); end
        apply_reset();
        tick();
        n_tests++; if (obs_gnt !== '0 || obs_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL idle_after_reset gnt %b busy %b expected 0 0", obs_gnt, obs_busy); end
    endtask

    task automatic test_single();
        int xv[5] = '{1, 5, 200, 0, 639};
        int yv[5] = '{0, 1, 200, 120, 479};
        int av[5] = '{1, 645, 128200, 76800, 307199};
        int ge[5];
        int kin;
        int kout;
        kin  = 0;
        kout = 0;
        apply_reset();
        for (int c = 0; c < 20 && kout < 5; c++) begin
            if (kin < 5) begin
                req = 3'b001;
                set_xy(0, xv[kin], yv[kin]);
            end else begin
                req = '0;
            end
            tick();
            n_tests++; if (obs_gnt !== exp_gnt) begin n_fail++; $display("[TB] FAIL single_gnt got %b expected %b", obs_gnt, exp_gnt); end
            if (obs_valid) begin
                n_tests++;
                if (obs_addr !== AW'(av[kout]) || obs_tag !== '0 || obs_err !== 1'b0) begin
                    n_fail++; $display("[TB] FAIL single_out[%0d] got addr %0d tag %0d err %b expected %0d 0 0", kout, obs_addr, obs_tag, obs_err, av[kout]);
                end
                n_tests++; if (edge_cnt != ge[kout] + 2) begin n_fail++; $display("[TB] FAIL single_latency[%0d] got edge %0d expected %0d", kout, edge_cnt, ge[kout] + 2); end
                kout++;
            end
            if (exp_gnt[0] && kin < 5) begin
                ge[kin] = edge_cnt;
                kin++;
            end
        end
        n_tests++; if (kout != 5) begin n_fail++; $display("[TB] FAIL single_count got %0d expected 5", kout); end
    endtask

    task automatic test_alternate();
        int kout;
        kout = 0;
        apply_reset();
        set_xy(0, 10, 0);
        set_xy(1, 20, 0);
        req = 3'b011;
        for (int c = 0; c < 8; c++) begin
            logic [NR-1:0] want;
            want = 3'b001 << (c % 2);
            tick();
            n_tests++; if (obs_gnt !== want) begin n_fail++; $display("[TB] FAIL alt_gnt[%0d] got %b expected %b", c, obs_gnt, want); end
            if (obs_valid) begin
                n_tests++;
                if (obs_addr !== AW'((kout % 2) ? 20 : 10) || obs_tag !== TW'(kout % 2)) begin
                    n_fail++; $display("[TB] FAIL alt_out[%0d] got addr %0d tag %0d expected %0d %0d", kout, obs_addr, obs_tag, (kout % 2) ? 20 : 10, kout % 2);
                end
                kout++;
            end
        end
        n_tests++; if (kout != 6) begin n_fail++; $display("[TB] FAIL alt_count got %0d expected 6", kout); end
    endtask

    task automatic test_stall();
        int            gcnt;
        int            drained;
        bit            held;
        logic [AW-1:0] hold_addr;
        logic [TW-1:0] hold_tag;
        gcnt    = 0;
        drained = 0;
        held    = 0;
        apply_reset();
        set_xy(0, $urandom_range(0, W - 1), $urandom_range(0, H - 1));
        set_xy(1, $urandom_range(0, W - 1), $urandom_range(0, H - 1));
        req   = 3'b011;
        ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            gcnt += $countones(obs_gnt);
            n_tests++; if (obs_gnt !== exp_gnt) begin n_fail++; $display("[TB] FAIL stall_gnt[%0d] got %b expected %b", c, obs_gnt, exp_gnt); end
            if (held) begin
                n_tests++; if (obs_addr !== hold_addr || obs_tag !== hold_tag || obs_valid !== 1'b1) begin
                    n_fail++; $display("[TB] FAIL stall_stable got %0d/%0d v%b expected %0d/%0d v1", obs_addr, obs_tag, obs_valid, hold_addr, hold_tag);
                end
            end else if (obs_valid) begin
                held      = 1;
                hold_addr = obs_addr;
                hold_tag  = obs_tag;
            end
        end
        n_tests++; if (gcnt != 2) begin n_fail++; $display("[TB] FAIL stall_captured got %0d expected 2", gcnt); end
        req   = '0;
        ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (obs_valid) begin
                n_tests++;
                if (!exp_valid || obs_addr !== AW'(head.addr) || obs_tag !== TW'(head.tag)) begin
                    n_fail++; $display("[TB] FAIL stall_drain got %0d/%0d expected %0d/%0d", obs_addr, obs_tag, head.addr, head.tag);
                end
                drained++;
            end
        end
        n_tests++; if (drained != 2 || obs_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_drain_count got %0d busy %b expected 2 0", drained, obs_busy); end
    endtask

    task automatic test_out_of_range();
        int xv[2] = '{640, 0};
        int yv[2] = '{0, 480};
        int ea[2];
        int kin;
        int kout;
`ifdef COORD_CLIP_EN
        ea = '{639, 306560};
`else
        ea = '{640, 307200};
`endif
        kin  = 0;
        kout = 0;
        apply_reset();
        for (int c = 0; c < 10 && kout < 2; c++) begin
            if (kin < 2) begin
                req = 3'b001;
                set_xy(0, xv[kin], yv[kin]);
            end else begin
                req = '0;
            end
            tick();
            if (obs_valid) begin
                n_tests++;
                if (obs_addr !== AW'(ea[kout]) || obs_err !== 1'b1) begin
                    n_fail++; $display("[TB] FAIL oor[%0d] got addr %0d err %b expected %0d 1", kout, obs_addr, obs_err, ea[kout]);
                end
                kout++;
            end
            if (exp_gnt[0] && kin < 2) kin++;
        end
        n_tests++; if (kout != 2) begin n_fail++; $display("[TB] FAIL oor_count got %0d expected 2", kout); end
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 600; c++) begin
            ready = ($urandom_range(0, 3) != 0);
            tick();
            n_tests++; if (obs_gnt !== exp_gnt) begin n_fail++; $display("[TB] FAIL rand_gnt[%0d] got %b expected %b", c, obs_gnt, exp_gnt); end
            n_tests++; if (obs_valid !== exp_valid) begin n_fail++; $display("[TB] FAIL rand_valid[%0d] got %b expected %b", c, obs_valid, exp_valid); end
            if (exp_valid) begin
                n_tests++;
                if (obs_addr !== AW'(head.addr) || obs_tag !== TW'(head.tag) || obs_err !== head.err) begin
                    n_fail++; $display("[TB] FAIL rand_out[%0d] got %0d/%0d/%b expected %0d/%0d/%b", c, obs_addr, obs_tag, obs_err, head.addr, head.tag, head.err);
                end
            end
            n_tests++; if (obs_busy !== exp_busy) begin n_fail++; $display("[TB] FAIL rand_busy[%0d] got %b expected %b", c, obs_busy, exp_busy); end
            for (int r = 0; r < NR; r++) begin
                if (exp_gnt[r] || !req[r]) begin
                    req[r] = ($urandom_range(0, 2) != 0);
                    set_xy(r, $urandom_range(0, 700), $urandom_range(0, 520));
                end else if ($urandom_range(0, 30) == 0) begin
                    req[r] = 1'b0;
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        set_xy(0, 3, 2);
        set_xy(1, 7, 1);
        req   = 3'b001;
        ready = 1'b0;
        repeat (3) tick();
        n_tests++; if (valid !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_prefill valid %b busy %b expected 1 1", valid, busy); end
        req = 3'b011;
        #2 rst_n = 1'b0;
        #1;
        n_tests++; if (valid !== 1'b0 || gnt !== '0 || busy !== 1'b0) begin
            n_fail++; $display("[TB] FAIL mid_reset valid %b gnt %b busy %b expected 0 0 0", valid, gnt, busy);
        end
        @(posedge clk);
        #2 rst_n = 1'b1;
        q.delete();
        ptr_m = 0;
        ready = 1'b1;
        tick();
        n_tests++; if (obs_gnt !== 3'b001) begin n_fail++; $display("[TB] FAIL mid_first_gnt got %b expected 001", obs_gnt); end
        req = '0;
        repeat (2) tick();
        n_tests++; if (obs_valid !== 1'b1 || obs_addr !== AW'(2 * W + 3) || obs_tag !== '0) begin
            n_fail++; $display("[TB] FAIL mid_first_out got v%b %0d/%0d expected v1 %0d/0", obs_valid, obs_addr, obs_tag, 2 * W + 3);
        end
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        edge_cnt = 0;
        ptr_m    = 0;
        test_reset();
        test_single();
        test_alternate();
        test_stall();
        test_out_of_range();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
